// File: rtl/bus_arbiter_8way_pkg.sv
// Shared definitions for the 8-way round-robin bus arbiter.
//   N_REQ       : number of requesters
//   SEL_W       : width of the owner index / mux select
//   arb_state_e : arbiter FSM state encoding
package bus_arbiter_8way_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/mux_8way.sv
// 8-to-1 byte multiplexer for the shared data bus.
//   d0..d7 : input bytes
//   sel    : select index
//   y      : selected byte
module mux_8way (
   input  logic [7:0] d0,
   input  logic [7:0] d1,
   input  logic [7:0] d2,
   input  logic [7:0] d3,
   input  logic [7:0] d4,
   input  logic [7:0] d5,
   input  logic [7:0] d6,
   input  logic [7:0] d7,
   input  logic [2:0] sel,
   output logic [7:0] y
);

   always_comb begin
      y = d0;
      unique case (sel)
         3'd0:    y = d0;
         3'd1:    y = d1;
         3'd2:    y = d2;
         3'd3:    y = d3;
         3'd4:    y = d4;
         3'd5:    y = d5;
         3'd6:    y = d6;
         3'd7:    y = d7;
         default: y = d0;
      endcase
   end

endmodule

// File: rtl/rr_pick8.sv
// Round-robin winner search over eight request lines.
// The search starts at ptr and takes the first set bit in ptr, ptr+1, ... ptr+7 (mod 8).
//   req : request vector
//   ptr : highest-priority index
//   any : at least one request is set
//   idx : index of the winner (only meaningful when any is high)
module rr_pick8
   import bus_arbiter_8way_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] off;

   // rot[i] is the request sitting i positions after ptr.
   always_comb begin
      rot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rot[i] = req[SEL_W'(ptr + SEL_W'(i))];
      end
   end

   // Lowest set bit of the rotated vector; scanning downward lets the lowest one win.
   always_comb begin
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = SEL_W'(i);
         end
      end
   end

   assign any = |req;
   assign idx = ptr + off;

endmodule

// File: rtl/bus_arbiter_8way.sv
// Round-robin arbiter and sequencer for the shared 8-bit data bus.
// Grants one requester at a time, holds the grant while the owner's request
// stays high, and drives the bus mux select with the owner's index.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after HOLD_MAX grant cycles).
//
// State table:
//   IDLE  | no owner; arbitrate among pending requests
//   GRANT | owner slct holds the bus until its request drops (or hold timeout)
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   req       : request bit per requester
//   d0..d7    : requester data bytes
//   gnt       : one-hot grant, registered
//   slct      : owner index, registered
//   bus_out   : owner's byte, zero when bus_valid is low
//   bus_valid : high while in GRANT
//   timeout   : one-cycle pulse on forced release (0 without ARB_TIMEOUT_EN)
module bus_arbiter_8way
   import bus_arbiter_8way_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [7:0]       d0,
   input  logic [7:0]       d1,
   input  logic [7:0]       d2,
   input  logic [7:0]       d3,
   input  logic [7:0]       d4,
   input  logic [7:0]       d5,
   input  logic [7:0]       d6,
   input  logic [7:0]       d7,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] slct,
   output logic [7:0]       bus_out,
   output logic             bus_valid,
   output logic             timeout
);

   arb_state_e       state_q;
   logic [SEL_W-1:0] ptr_q;
   logic [SEL_W-1:0] ptr_d;
   logic [N_REQ-1:0] gnt_q;
   logic [SEL_W-1:0] slct_q;
   logic             valid_q;
   logic             pick_any;
   logic [SEL_W-1:0] pick_idx;
   logic             force_rel;
   logic [7:0]       mux_y;

   rr_pick8 u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   mux_8way u_mux (
      .d0  (d0),
      .d1  (d1),
      .d2  (d2),
      .d3  (d3),
      .d4  (d4),
      .d5  (d5),
      .d6  (d6),
      .d7  (d7),
      .sel (slct_q),
      .y   (mux_y)
   );

   // Priority moves to the requester after the one being released.
   assign ptr_d = slct_q + SEL_W'(1);

`ifdef ARB_TIMEOUT_EN
   // The counter is 0 in the first GRANT cycle, so it would reach HOLD_MAX at
   // the edge ending grant cycle HOLD_MAX; release is decided one count earlier.
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
   logic [7:0] hold_cnt_q;
   logic       timeout_q;
   assign force_rel = (hold_cnt_q == HOLD_LAST);
   assign timeout   = timeout_q;
`else
   // Never true for a legal HOLD_MAX (1..255): grants are held indefinitely.
   assign force_rel = (HOLD_MAX == 0);
   assign timeout   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         gnt_q      <= '0;
         slct_q     <= '0;
         valid_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               if (pick_any) begin
                  state_q    <= GRANT;
                  gnt_q      <= N_REQ'(1) << pick_idx;
                  slct_q     <= pick_idx;
                  valid_q    <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  hold_cnt_q <= '0;
`endif
               end
            end
            GRANT: begin
`ifdef ARB_TIMEOUT_EN
               hold_cnt_q <= hold_cnt_q + 8'd1;
`endif
               if (!req[slct_q] || force_rel) begin
                  state_q   <= IDLE;
                  gnt_q     <= '0;
                  valid_q   <= 1'b0;
                  ptr_q     <= ptr_d;
`ifdef ARB_TIMEOUT_EN
                  // A simultaneous normal release still reports as a timeout.
                  timeout_q <= force_rel;
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign slct      = slct_q;
   assign bus_valid = valid_q;
   assign bus_out   = mux_y & {8{valid_q}};

endmodule

// File: tb/tb_bus_arbiter_8way.sv
module tb_bus_arbiter_8way;

   localparam int HOLD = 4;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] slct;
      logic       chk_slct;
      logic       valid;
      logic [7:0] bus;
      logic       to;
   } exp_t;

   typedef struct packed {
      logic       rst;
      logic [7:0] req;
      exp_t       e;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] dv [8];
   logic [7:0] gnt;
   logic [2:0] slct;
   logic [7:0] bus_out;
   logic       bus_valid;
   logic       timeout;

   int   checks;
   int   errors;
   exp_t sb_q [$];
   vec_t vecs [$];

   bus_arbiter_8way #(.HOLD_MAX(HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .d0        (dv[0]),
      .d1        (dv[1]),
      .d2        (dv[2]),
      .d3        (dv[3]),
      .d4        (dv[4]),
      .d5        (dv[5]),
      .d6        (dv[6]),
      .d7        (dv[7]),
      .gnt       (gnt),
      .slct      (slct),
      .bus_out   (bus_out),
      .bus_valid (bus_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t granted(input int k);
      exp_t e;
      e.gnt      = 8'(1 << k);
      e.slct     = 3'(k);
      e.chk_slct = 1'b1;
      e.valid    = 1'b1;
      e.bus      = dv[k];
      e.to       = 1'b0;
      return e;
   endfunction

   function automatic exp_t idle(input logic to, input logic after_reset);
      exp_t e;
      e.gnt      = 8'h00;
      e.slct     = 3'd0;
      e.chk_slct = after_reset;
      e.valid    = 1'b0;
      e.bus      = 8'h00;
      e.to       = to;
      return e;
   endfunction

   task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, step, act, req_v);
      end
   endtask

   // Drive one cycle of stimulus; the expectation is queued with the stimulus
   // and popped once the edge it describes has happened.
   task automatic cycle(input string name, input int step, input logic rst_v, input logic [7:0] req_v, input exp_t e);
      exp_t got;
      rst_n = rst_v;
      req   = req_v;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      chk({name, ".gnt"}, step, gnt, got.gnt);
      if (got.chk_slct) chk({name, ".slct"}, step, {5'd0, slct}, {5'd0, got.slct});
      chk({name, ".valid"}, step, {7'd0, bus_valid}, {7'd0, got.valid});
      chk({name, ".bus_out"}, step, bus_out, got.bus);
      chk({name, ".timeout"}, step, {7'd0, timeout}, {7'd0, got.to});
   endtask

   task automatic do_reset(input string name);
      cycle(name, 0, 1'b0, 8'h00, idle(1'b0, 1'b1));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      req    = 8'hFF;
      for (int i = 0; i < 8; i++) dv[i] = 8'(8'hA0 + i * 8'h11);
      dv[3] = 8'h28;

      // Round-robin table: from reset, owners 0..7 then 0 again, each holding
      // two cycles and then dropping its own bit for one cycle.
      vecs.push_back('{rst: 1'b0, req: 8'hFF, e: idle(1'b0, 1'b1)});
      for (int k = 0; k <= 8; k++) begin
         int o;
         o = k % 8;
         vecs.push_back('{rst: 1'b1, req: 8'hFF, e: granted(o)});
         vecs.push_back('{rst: 1'b1, req: 8'hFF, e: granted(o)});
         vecs.push_back('{rst: 1'b1, req: 8'(8'hFF & ~(8'h01 << o)), e: idle(1'b0, 1'b0)});
      end

      // Reset held with all requests pending.
      for (int i = 0; i < 3; i++) cycle("reset", i, 1'b0, 8'hFF, idle(1'b0, 1'b1));

      // Single request from requester 3.
      cycle("single", 0, 1'b1, 8'h00, idle(1'b0, 1'b1));
      cycle("single", 1, 1'b1, 8'h08, granted(3));
      cycle("single", 2, 1'b1, 8'h08, granted(3));
      cycle("single", 3, 1'b1, 8'h00, idle(1'b0, 1'b0));
      cycle("single", 4, 1'b1, 8'h00, idle(1'b0, 1'b0));

      // Round robin from the table.
      for (int i = 0; i < vecs.size(); i++) cycle("rrobin", i, vecs[i].rst, vecs[i].req, vecs[i].e);

      // Pointer wrap: after owner 6 releases, ptr=7 so 0 beats 6.
      do_reset("wrap");
      cycle("wrap", 1, 1'b1, 8'h40, granted(6));
      cycle("wrap", 2, 1'b1, 8'h00, idle(1'b0, 1'b0));
      cycle("wrap", 3, 1'b1, 8'h41, granted(0));
      cycle("wrap", 4, 1'b1, 8'h41, granted(0));
      cycle("wrap", 5, 1'b1, 8'h40, idle(1'b0, 1'b0));
      cycle("wrap", 6, 1'b1, 8'h40, granted(6));

      // Reset mid-grant: re-arbitration restarts from ptr=0, so 4 beats 7.
      do_reset("midrst");
      cycle("midrst", 1, 1'b1, 8'h10, granted(4));
      cycle("midrst", 2, 1'b1, 8'h90, granted(4));
      cycle("midrst", 3, 1'b0, 8'h90, idle(1'b0, 1'b1));
      cycle("midrst", 4, 1'b1, 8'h90, granted(4));
      cycle("midrst", 5, 1'b1, 8'h80, idle(1'b0, 1'b0));
      cycle("midrst", 6, 1'b1, 8'h80, granted(7));

      // Hold timeout: requester 2 holds, requester 5 pending.
      do_reset("hold");
      cycle("hold", 1, 1'b1, 8'h24, granted(2));
      for (int i = 1; i < 20; i++) begin
`ifdef ARB_TIMEOUT_EN
         int ph;
         ph = i % (HOLD + 1);
         if (ph == HOLD) cycle("hold", i + 1, 1'b1, 8'h24, idle(1'b1, 1'b0));
         else cycle("hold", i + 1, 1'b1, 8'h24, granted(((i / (HOLD + 1)) % 2 == 1) ? 5 : 2));
`else
         cycle("hold", i + 1, 1'b1, 8'h24, granted(2));
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_8way.md
# bus_arbiter_8way

Round-robin arbiter and sequencer for the shared 8-bit data bus. Up to eight requesters compete for the bus. The arbiter grants one at a time and drives the 3-bit select of the 8-way bus mux with the owner's index, so the owner's byte appears on the bus. It sits between the requesting units (register file ports, ALU, I/O) and the bus consumers.

## Interface
Parameters:
- HOLD_MAX, 16: maximum cycles a grant may be held before forced release (range 1–255; used only with ARB_TIMEOUT_EN).

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req  in  8  request bit per requester; held high while the bus is wanted
- d0..d7  in  8 each  requester data bytes
- gnt  out  8  one-hot grant, registered
- slct  out  3  index of the current owner, registered; feeds the mux
- bus_out  out  8  byte selected by slct; 8'h00 when bus_valid is low
- bus_valid  out  1  high while in GRANT
- timeout  out  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN

## Operation
- The FSM has two states, IDLE and GRANT. A 3-bit round-robin pointer ptr holds the highest-priority index.
- IDLE, req == 0: stay in IDLE.
- IDLE, req != 0:
  - Winner = first set bit scanning ptr, ptr+1, …, ptr+7 (mod 8).
  - Next edge: state=GRANT, gnt=1<<winner, slct=winner.
- GRANT, req[slct]=1: hold; gnt and slct are stable.
- GRANT, req[slct]=0: next edge: state=IDLE, gnt=0, ptr=slct+1 mod 8. Index 7 wraps to 0.
- Requests from non-owners are ignored during GRANT. There is no preemption.
- bus_out = selected byte AND {8{bus_valid}}. This path is combinational from d* and registered slct.
- Reset values: state=IDLE, ptr=0, gnt=8'h00, slct=0, bus_valid=0, bus_out=8'h00, timeout=0, hold counter=0.
- Reset mid-grant: all state returns to the reset values at the next edge. Pending requests are re-arbitrated from ptr=0.

## Timing
- Grant latency: req seen at edge N leads to gnt/slct/bus_valid valid after edge N+1.
- Release latency: owner's req low at edge M leads to gnt=0 after edge M+1.
- Every handover spends exactly one IDLE cycle between grants. There are no back-to-back grants.
- A single continuous requester gets release, one IDLE cycle, then a regrant. Other requesters win first if they are at or after ptr.
- bus_out changes in the same cycle as slct, with no extra latency.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches HOLD_MAX, the grant is forced to release exactly as a normal release (next state IDLE, ptr advances), and timeout pulses for one cycle together with gnt dropping.
  - A normal release and a timeout in the same cycle count as a timeout.
- ARB_TIMEOUT_EN undefined: no counter, timeout=0, and grants are held indefinitely.

## Structure
- Shared package:
  - N_REQ=8 and SEL_W=3.
  - FSM state encoding: IDLE=1'b0, GRANT=1'b1.
- Sub-module: instantiate the existing mux_8way for bus_out, then gate its output with bus_valid.
- Keep the rotate-and-priority-encode winner search in a sub-module, rr_pick8 (inputs req, ptr; outputs any, idx).

## Test plan
- Reset: hold rst_n=0 with req=8'hFF for 3 cycles -> gnt=0, slct=0, bus_valid=0, bus_out=0, timeout=0.
- Single request: d3=8'h28, req=8'h08 at edge 5 -> after edge 6, gnt=8'h08, slct=3, bus_out=8'h28; drop req -> gnt=0 and bus_out=0 one edge later.
- Round robin: req=8'hFF, each owner drops its bit for one cycle after 2 grant cycles -> grant order 0,1,2,…,7,0, with one idle cycle between grants.
- Pointer wrap: after owner 6 releases (ptr=7), req=8'h41 -> grant goes to 0, not 6.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): req[2] held for 20 cycles and req[5] pending -> gnt[2] drops after 4 grant cycles with a one-cycle timeout pulse, then gnt=8'h20. Without the macro, gnt[2] persists for all 20 cycles.
- Reset mid-grant: during gnt=8'h10, pulse rst_n=0 for one cycle with req=8'h90 -> reset values, then gnt=8'h10 (ptr=0 scan reaches 4 before 7).
